// File: rtl/neopixel_pkg.sv
// Shared NeoPixel (WS2812) definitions used by both the transmitter and
// the receiver: protocol state encoding, nominal bit timing in ns, and a
// helper converting ns to i_clk ticks.
package neopixel_pkg;

  typedef enum logic [1:0] {
    SYNC,  // wait for a full reset gap before trusting the line
    IDLE,  // armed, waiting for the first rising edge of a frame
    HI,    // measuring a high pulse
    LO     // between bits, watching for the next rise or the reset gap
  } np_state_t;

  localparam int unsigned T0H_NS     = 350;
  localparam int unsigned T1H_NS     = 700;
  localparam int unsigned T0L_NS     = 800;
  localparam int unsigned T1L_NS     = 600;
  localparam int unsigned RST_NS     = 50_000;
  localparam int unsigned BIT_THR_NS = 525;
  localparam int unsigned MIN_HI_NS  = 150;
  localparam int unsigned MAX_HI_NS  = 1000;
  localparam int unsigned RST_DET_NS = 20_000;

  // 64-bit intermediate: CLK_HZ * ns overflows 32 bits for the reset gap.
  function automatic int unsigned ns_to_tck(input int unsigned clk_hz,
                                            input int unsigned ns);
    longint unsigned p;
    p = longint'(clk_hz) * longint'(ns);
    return int'(p / 64'd1_000_000_000);
  endfunction

endpackage

// File: rtl/neopixel_receiver_if.sv
// Frame-buffer write port of the NeoPixel receiver.
//   o_wr_en   : one-cycle byte write strobe
//   o_wr_addr : byte address, 0 = first byte of the frame
//   o_wr_data : received byte
// master = receiver (drives), slave = frame buffer (consumes).
interface neopixel_receiver_if #(
  parameter int LEDS = 200
);
  localparam int AW = $clog2(LEDS*3);

  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data;

  modport master (output o_wr_en, output o_wr_addr, output o_wr_data);
  modport slave  (input  o_wr_en, input  o_wr_addr, input  o_wr_data);
endinterface

// File: rtl/neopixel_pulse_meter.sv
// Input conditioning for the NeoPixel receiver: 2-FF synchronizer, a
// delayed copy for edge detection, and a saturating level-duration counter.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_din          : asynchronous serial line
//   o_rise/o_fall  : one-cycle edge strobes
//   o_level        : line level, aligned with the strobes
//   o_count        : cycles the line has held o_level, including this one;
//                    on a strobe cycle it still holds the length of the
//                    level that just ended
module neopixel_pulse_meter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_din,
  output logic        o_rise,
  output logic        o_fall,
  output logic        o_level,
  output logic [15:0] o_count
);

  logic        r_s1, r_s2, r_s3;
  logic        r_rise, r_fall;
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= 16'd0;
    end else begin
      r_s1   <= i_din;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
      // Restart one cycle after the strobe so the strobe cycle can still
      // report the finished pulse length.
      if (r_rise | r_fall)      r_cnt <= 16'd1;
      else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_level = r_s3;
  assign o_count = r_cnt;

endmodule

// File: rtl/neopixel_receiver.sv
// NeoPixel (WS2812) NRZ receiver: decodes high-pulse widths into bits,
// packs them MSB-first into bytes and writes byte k of a frame to address k.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_din          : asynchronous serial line
//   wr             : frame-buffer write port (master)
//   o_busy         : frame in progress
//   o_frame_done   : one-cycle pulse at end of frame (reset gap)
//   o_frame_bytes  : bytes written in the last frame
//   o_err          : pulse on glitch, over-long high, or partial final byte
//   o_overflow     : sticky per frame, more bytes than the buffer holds
module neopixel_receiver
  import neopixel_pkg::*;
#(
  parameter int LEDS        = 200,
  parameter int CLK_HZ      = 50_000_000,
  parameter int BIT_THR_NS  = 525,
  parameter int MIN_HI_NS   = 150,
  parameter int MAX_HI_NS   = 1000,
  parameter int RST_DET_NS  = 20_000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_din,
  neopixel_receiver_if.master           wr,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic [$clog2(LEDS*3+1)-1:0]   o_frame_bytes,
  output logic                          o_err,
  output logic                          o_overflow
);

  localparam int DEPTH = LEDS*3;
  localparam int AW    = $clog2(DEPTH);
  localparam int FBW   = $clog2(DEPTH+1);

  localparam logic [15:0] BIT_THR_TCK = 16'(ns_to_tck(CLK_HZ, BIT_THR_NS));
  localparam logic [15:0] MIN_HI_TCK  = 16'(ns_to_tck(CLK_HZ, MIN_HI_NS));
  localparam logic [15:0] MAX_HI_TCK  = 16'(ns_to_tck(CLK_HZ, MAX_HI_NS));
  localparam logic [15:0] RST_DET_TCK = 16'(ns_to_tck(CLK_HZ, RST_DET_NS));

  logic        w_rise, w_fall, w_level;
  logic [15:0] w_cnt;

  neopixel_pulse_meter u_meter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_din   (i_din),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_level (w_level),
    .o_count (w_cnt)
  );

  np_state_t      r_state, w_state_nxt;
  logic [2:0]     r_bitcnt, w_bitcnt_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [FBW-1:0] r_addr, w_addr_nxt;
  logic           r_wr_en, w_wr_en_nxt;
  logic [AW-1:0]  r_wr_addr, w_wr_addr_nxt;
  logic [7:0]     r_wr_data, w_wr_data_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic [FBW-1:0] r_fbytes, w_fbytes_nxt;
  logic           r_err, w_err_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic [7:0]     w_byte;

  assign w_byte = {r_shift[6:0], (w_cnt >= BIT_THR_TCK)};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= SYNC;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fbytes  <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_fbytes  <= w_fbytes_nxt;
      r_err     <= w_err_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_addr_nxt    = r_addr;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_fbytes_nxt  = r_fbytes;
    w_err_nxt     = 1'b0;
    w_ovf_nxt     = r_ovf;
    unique case (r_state)
      SYNC: begin
        // A fall strobe carries the high length, not a low length.
        if (!w_level && !w_fall && w_cnt >= RST_DET_TCK) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_rise) begin
          w_state_nxt  = HI;
          w_busy_nxt   = 1'b1;
          w_addr_nxt   = '0;
          w_ovf_nxt    = 1'b0;
          w_bitcnt_nxt = '0;
        end
      end
      HI: begin
        if ((w_fall && (w_cnt < MIN_HI_TCK || w_cnt > MAX_HI_TCK)) ||
            (w_level && w_cnt > MAX_HI_TCK)) begin
          // Abort: bytes already written stay in the buffer.
          w_err_nxt    = 1'b1;
          w_busy_nxt   = 1'b0;
          w_bitcnt_nxt = '0;
          w_state_nxt  = SYNC;
        end else if (w_fall) begin
          w_shift_nxt  = w_byte;
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          w_state_nxt  = LO;
          if (r_bitcnt == 3'd7) begin
            if (r_addr < FBW'(DEPTH)) begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = AW'(r_addr);
              w_wr_data_nxt = w_byte;
              w_addr_nxt    = r_addr + FBW'(1);
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
        end
      end
      LO: begin
        if (w_rise) begin
          w_state_nxt = HI;
        end else if (w_cnt >= RST_DET_TCK) begin
          w_done_nxt   = 1'b1;
          w_fbytes_nxt = r_addr;
          w_busy_nxt   = 1'b0;
          w_err_nxt    = (r_bitcnt != 3'd0);
          w_bitcnt_nxt = '0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  assign wr.o_wr_en    = r_wr_en;
  assign wr.o_wr_addr  = r_wr_addr;
  assign wr.o_wr_data  = r_wr_data;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_done;
  assign o_frame_bytes = r_fbytes;
  assign o_err         = r_err;
  assign o_overflow    = r_ovf;

endmodule

// File: doc/neopixel_receiver.md
Name: neopixel_receiver

Overview:
- Decodes a WS2812-style single-wire NRZ pulse stream: samples the data line, measures each high pulse, and assembles bits MSB-first into bytes.
- Writes each byte into a frame buffer through a simple write port; detects the inter-frame reset gap as end of frame.
- Serves as the receive end of the NeoPixel link, for loopback test of the transmitter and for capture of frames from an external controller.
- Byte k of a frame goes to address k. This is the same address order the transmitter uses when reading, so loopback data lands at identical addresses.

Parameters:
- LEDS, 200, pixels per frame; buffer depth is LEDS*3 bytes.
- CLK_HZ, 50_000_000, i_clk frequency.
- BIT_THR_NS, 525, high pulse >= this decodes as 1, shorter as 0.
- MIN_HI_NS, 150, high pulse shorter than this is a glitch.
- MAX_HI_NS, 1000, high pulse longer than this is a protocol error.
- RST_DET_NS, 20_000, continuous low of at least this long ends a frame or arms the receiver.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_din  in  1  asynchronous serial data line
- o_wr_en  out  1  one-cycle byte write strobe
- o_wr_addr  out  $clog2(LEDS*3)  byte address, 0 = first byte of frame
- o_wr_data  out  8  received byte
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_frame_bytes  out  $clog2(LEDS*3+1)  bytes written in the last frame; valid from o_frame_done onward
- o_err  out  1  one-cycle pulse on a glitch, over-long high, or partial byte at frame end
- o_overflow  out  1  sticky for the current frame: more than LEDS*3 bytes received

Behaviour:
- Tick constants: X_TCK = CLK_HZ*X_NS/1e9. At defaults: BIT_THR = 26, MIN_HI = 7, MAX_HI = 50, RST_DET = 1000.
- Input path:
  - 2-FF synchronizer on i_din, reset to 0.
  - One delayed copy of the synchronized signal gives rise and fall detection.
- Counters:
  - Pulse counter: 16 bits, saturating, cleared on each detected edge.
  - Bit counter: 3 bits.
  - Shift register: 8 bits.
  - Address counter: as wide as o_frame_bytes.
- Reset values: all outputs 0, state SYNC, all counters 0.
- State SYNC:
  - Counts cycles the synchronized line is low; any high clears the count.
  - Count reaching RST_DET_TCK -> IDLE.
  - Entered after reset, so a frame already in progress at reset release is ignored entirely.
- State IDLE: on rise -> HI, set o_busy=1, clear address counter, clear o_overflow.
- State HI (count cycles while high), on fall:
  - count < MIN_HI_TCK -> o_err pulse, o_busy=0, -> SYNC; the frame is aborted and bytes already written stay.
  - count >= BIT_THR_TCK -> shift in 1; otherwise shift in 0. Then -> LO.
  - If count exceeds MAX_HI_TCK while still high -> o_err pulse, o_busy=0, -> SYNC.
- Byte completion (8th bit shifted):
  - Address < LEDS*3: o_wr_en=1 for one cycle with o_wr_addr = address and o_wr_data = byte; then address counter +1.
  - Otherwise: byte dropped, o_overflow=1.
- Write latency: o_wr_en is registered and asserts exactly 4 i_clk after the i_din falling edge that ends the 8th bit (2 sync + 1 edge detect + 1 output register).
- State LO:
  - On rise -> HI.
  - Low count reaching RST_DET_TCK -> frame end: o_frame_done pulse, o_frame_bytes = address counter, o_busy=0, -> IDLE.
  - If a partial byte is pending at frame end (bit counter != 0): the partial byte is discarded and o_err pulses in the same cycle as o_frame_done.
- Simultaneous events:
  - A write and o_frame_done never coincide: a rise is needed before the next RST_DET window can complete.
  - o_overflow holds until the next frame starts in IDLE.
- o_frame_bytes holds its value until the next o_frame_done.
- Reset asserted mid-operation: immediate return to reset values; no write is issued for a partial byte.

Decomposition:
- Shared package neopixel_pkg holds:
  - the protocol state enum (SYNC, IDLE, HI, LO);
  - timing constants in ns (T0H 350, T1H 700, T0L 800, T1L 600, RST 50_000, BIT_THR 525, MIN_HI 150, MAX_HI 1000, RST_DET 20_000);
  - a tick-conversion function.
  The transmitter and receiver both use this package.
- Sub-module neopixel_pulse_meter contains the synchronizer, edge detect and saturating pulse counter. Its outputs are rise, fall, level and count.

Test Plan (CLK_HZ = 50 MHz):
- Hold i_din low 1000 cycles, send 0xA5, 0x3C, 0xFF (T1H 35, T0H 17 cycles), then 50 us low -> writes (0,A5), (1,3C), (2,FF); o_frame_done pulse; o_frame_bytes = 3; o_err = 0.
- Threshold check: high 25 cycles -> decoded 0; high 26 cycles -> decoded 1. Byte of alternating 25/26-cycle pulses starting with 26 -> 0xAA.
- Loopback with the transmitter, LEDS = 4, buffer loaded with 0x00..0x0B -> 12 writes with addr k = data k; o_frame_bytes = 12; write at 4 cycles after each 8th-bit fall.
- Glitch high of 4 cycles mid-byte -> o_err pulse, o_busy = 0, no further writes until 1000 low cycles; the next valid frame decodes normally.
- Overflow, LEDS = 2: send 7 bytes -> 6 writes (addr 0..5); o_overflow = 1; o_frame_bytes = 6. Separately, 5 bits then gap -> o_frame_done and o_err in the same cycle, no write for the partial byte.
- Assert i_rst_n = 0 during byte 2 -> all outputs 0. Release with the line still toggling -> no writes until 1000 consecutive low cycles.
